// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the CORDIC phase feeder.
package cordic_pkg;

    // Angle scale seen by the CORDIC core: 256 units per degree.
    localparam int ANGLE_UNITS_PER_DEG = 256;
    localparam int ANGLE_90            = 23040;
    localparam int ANGLE_45            = 11520;

    // Width of the core's signed cos/sin results (Q1.7).
    localparam int CORDIC_OUT_W = 8;

    typedef logic [1:0] quadrant_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } feeder_state_t;

    // Two's complement negation that maps the most negative code to the most positive.
    function automatic logic [CORDIC_OUT_W-1:0] sat_neg(input logic [CORDIC_OUT_W-1:0] x);
        logic [CORDIC_OUT_W-1:0] most_neg;
        most_neg = {1'b1, {(CORDIC_OUT_W-1){1'b0}}};
        if (x == most_neg) begin
            return {1'b0, {(CORDIC_OUT_W-1){1'b1}}};
        end
        return -x;
    endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// Small FIFO holding the quadrant tag of each angle issued to the CORDIC core.
// The head entry is visible on rd_data while not empty; pop advances it.
module cordic_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Push is dropped when full and pop when empty; both may happen together.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Tag storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cordic_phase_feeder.sv
// Phase accumulator, octant fold and quadrant correction around an iterative CORDIC core.
// Handshake: z_out/z_valid are held stable from the cycle z_valid rises until a cycle with
// z_ready high; that cycle is the transfer. z_valid never drops without a transfer.
module cordic_phase_feeder
    import cordic_pkg::*;
#(
    parameter int PHASE_W   = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          freq_load,
    input  logic [PHASE_W-1:0]            freq_word,
    output logic [15:0]                   z_out,
    output logic                          z_valid,
    input  logic                          z_ready,
    input  logic                          res_valid,
    input  logic [CORDIC_OUT_W-1:0]       res_cos,
    input  logic [CORDIC_OUT_W-1:0]       res_sin,
    output logic [CORDIC_OUT_W-1:0]       cos_out,
    output logic [CORDIC_OUT_W-1:0]       sin_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          err_orphan,
    output logic                          state_dbg,
    output logic [$clog2(TAG_DEPTH):0]    count_dbg
);

    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam int PW = PHASE_W + 16;

    feeder_state_t state_q;
    feeder_state_t state_d;

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] step_q;
    logic [PHASE_W-1:0] phase_adv;

    logic push;
    logic pop;
    logic load_z;
    logic will_be_full;

    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    quadrant_t       tag_head;

    logic [PHASE_W-1:0]          fold_u;
    quadrant_t                   fold_q;
    logic signed [PHASE_W-2:0]   fold_r;
    logic signed [PW-1:0]        fold_r_ext;
    logic signed [PW-1:0]        fold_k;
    logic signed [PW-1:0]        fold_prod;
    logic [15:0]                 fold_z;

    logic [CORDIC_OUT_W-1:0] cos_c;
    logic [CORDIC_OUT_W-1:0] sin_c;

    // A result pops the head tag only when one is in flight.
    assign pop          = res_valid && !fifo_empty;
    assign will_be_full = ((fifo_count + CW'(1) - CW'(pop)) == CW'(TAG_DEPTH));
    assign busy         = (fifo_count != '0);
    assign state_dbg    = state_q;
    assign count_dbg    = fifo_count;

    // Phase the next fold sees: a reload wins, otherwise advance on each transfer.
    always_comb begin
        phase_adv = phase_q;
        if (push)      phase_adv = phase_q + step_q;
        if (freq_load) phase_adv = '0;
    end

    // Rotate by 45 deg so each quadrant is centred on zero, then scale to angle units.
    always_comb begin
        fold_u     = phase_adv + {3'b001, {(PHASE_W-3){1'b0}}};
        fold_q     = fold_u[PHASE_W-1:PHASE_W-2];
        fold_r     = $signed({1'b0, fold_u[PHASE_W-3:0]}) - $signed({2'b01, {(PHASE_W-3){1'b0}}});
        fold_r_ext = {{(PW-PHASE_W+1){fold_r[PHASE_W-2]}}, fold_r};
        fold_k     = PW'(ANGLE_90);
        fold_prod  = fold_r_ext * fold_k;
        fold_z     = 16'(fold_prod >>> (PHASE_W-2));
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: stay in ISSUE across transfers while more angles are wanted and room remains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && !fifo_full) state_d = ISSUE;
            ISSUE:   if (z_ready && !(enable && !will_be_full)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: offer while in ISSUE, push on transfer, reload z_out when a new angle is presented.
    always_comb begin
        z_valid = (state_q == ISSUE);
        push    = (state_q == ISSUE) && z_ready;
        load_z  = ((state_q == IDLE) && enable && !fifo_full) ||
                  (push && enable && !will_be_full);
    end

    // Frequency step and phase accumulator.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            step_q  <= '0;
            phase_q <= '0;
        end else begin
            if (freq_load) step_q <= freq_word;
            phase_q <= phase_adv;
        end
    end

    // Angle register presented to the core; untouched while an offer is pending.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)       z_out <= '0;
        else if (load_z) z_out <= fold_z;
    end

    cordic_tag_fifo #(
        .WIDTH (2),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .push    (push),
        .wr_data (fold_q_at_issue()),
        .pop     (pop),
        .rd_data (tag_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Quadrant of the angle currently held in z_out, recovered from the phase it was folded from.
    function automatic quadrant_t fold_q_at_issue();
        logic [PHASE_W-1:0] u;
        u = phase_q + {3'b001, {(PHASE_W-3){1'b0}}};
        return u[PHASE_W-1:PHASE_W-2];
    endfunction

    // Map the core's first-octant-centred result back into the tagged quadrant.
    always_comb begin
        cos_c = res_cos;
        sin_c = res_sin;
        case (tag_head)
            2'd0: begin cos_c = res_cos;          sin_c = res_sin;          end
            2'd1: begin cos_c = sat_neg(res_sin); sin_c = res_cos;          end
            2'd2: begin cos_c = sat_neg(res_cos); sin_c = sat_neg(res_sin); end
            default: begin cos_c = res_sin;       sin_c = sat_neg(res_cos); end
        endcase
    end

    // Result register, one-cycle valid pulse, and sticky orphan-result flag.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cos_out    <= '0;
            sin_out    <= '0;
            out_valid  <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                cos_out <= cos_c;
                sin_out <= sin_c;
            end
            if (res_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    // fold_q describes the next angle to present, not the one being transferred.
    logic unused_fold_q;
    assign unused_fold_q = ^fold_q;

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Directed bench for cordic_phase_feeder: fold values, quadrant tags seen through
// corrected results, saturation, FIFO back-pressure, reset and orphan results.
module tb_cordic_phase_feeder;

    logic        CLK = 1'b0;
    logic        reset;
    logic        enable;
    logic        freq_load;
    logic [15:0] freq_word;
    logic [15:0] z_out;
    logic        z_valid;
    logic        z_ready;
    logic        res_valid;
    logic [7:0]  res_cos;
    logic [7:0]  res_sin;
    logic [7:0]  cos_out;
    logic [7:0]  sin_out;
    logic        out_valid;
    logic        busy;
    logic        err_orphan;
    logic        state_dbg;
    logic [2:0]  count_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_issue  = 0;
    logic [15:0] issued_q[$];

    cordic_phase_feeder #(
        .PHASE_W   (16),
        .TAG_DEPTH (4)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .enable     (enable),
        .freq_load  (freq_load),
        .freq_word  (freq_word),
        .z_out      (z_out),
        .z_valid    (z_valid),
        .z_ready    (z_ready),
        .res_valid  (res_valid),
        .res_cos    (res_cos),
        .res_sin    (res_sin),
        .cos_out    (cos_out),
        .sin_out    (sin_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .err_orphan (err_orphan),
        .state_dbg  (state_dbg),
        .count_dbg  (count_dbg)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // Record every transfer of an angle to the core (inputs are stable at the falling edge).
    always @(negedge CLK) begin
        if (z_valid === 1'b1 && z_ready === 1'b1) begin
            n_issue = n_issue + 1;
            issued_q.push_back(z_out);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_freq(input logic [15:0] w);
        freq_word = w;
        freq_load = 1'b1;
        tick();
        freq_load = 1'b0;
    endtask

    // Wait (bounded) for an offer, check the angle, transfer it; last drops enable on the transfer.
    task automatic do_issue(input logic signed [15:0] exp_z, input logic last, input string tag);
        int waited;
        waited = 0;
        while (z_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check_eq({tag, "_valid"}, 32'(z_valid), 1);
        check_eq(tag, $signed(z_out), exp_z);
        z_ready = 1'b1;
        enable  = !last;
        tick();
        z_ready = 1'b0;
    endtask

    // Return one core result and check the corrected pulse one cycle later.
    task automatic send_res(input logic signed [7:0] c, input logic signed [7:0] s,
                            input logic signed [7:0] exp_c, input logic signed [7:0] exp_s,
                            input string tag);
        res_valid = 1'b1;
        res_cos   = c;
        res_sin   = s;
        tick();
        res_valid = 1'b0;
        check_eq({tag, "_ov"},  32'(out_valid), 1);
        check_eq({tag, "_cos"}, $signed(cos_out), exp_c);
        check_eq({tag, "_sin"}, $signed(sin_out), exp_s);
        tick();
        check_eq({tag, "_pulse"}, 32'(out_valid), 0);
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        freq_load = 1'b0;
        freq_word = '0;
        z_ready   = 1'b0;
        res_valid = 1'b0;
        res_cos   = '0;
        res_sin   = '0;
        repeat (3) tick();
        check_eq("rst_z_out",  $signed(z_out), 0);
        check_eq("rst_z_valid", 32'(z_valid), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_busy",   32'(busy), 0);
        check_eq("rst_err",    32'(err_orphan), 0);
        check_eq("rst_state",  32'(state_dbg), 0);
        reset = 1'b0;
        tick();

        // Quarter-turn step, core always ready, no results: four zero angles then a stall.
        load_freq(16'h4000);
        z_ready = 1'b1;
        enable  = 1'b1;
        repeat (12) tick();
        check_eq("full_issues", n_issue, 4);
        for (int i = 0; i < 4; i++) check_eq("quarter_z", $signed(issued_q[i]), 0);
        check_eq("full_z_valid", 32'(z_valid), 0);
        check_eq("full_busy",    32'(busy), 1);
        check_eq("full_count",   32'(count_dbg), 4);
        send_res(8'sd127, 8'sd0, 8'sd127, 8'sd0, "q0");
        repeat (4) tick();
        check_eq("refill_issues", n_issue, 5);
        check_eq("refill_z", $signed(issued_q[4]), 0);
        check_eq("refill_z_valid", 32'(z_valid), 0);
        enable  = 1'b0;
        z_ready = 1'b0;
        send_res(8'sd127, 8'sd0, 8'sd0,    8'sd127,  "q1");
        send_res(8'sd127, 8'sd0, -8'sd127, 8'sd0,    "q2");
        send_res(8'sd127, 8'sd0, 8'sd0,    -8'sd127, "q3");
        send_res(8'sd127, 8'sd0, 8'sd127,  8'sd0,    "q0_wrap");
        check_eq("drain_busy", 32'(busy), 0);

        // Fold boundaries: phase 0x2000 -> -11520 in q1, phase 0x1FFF -> +11518 in q0.
        load_freq(16'h2000);
        enable = 1'b1;
        do_issue(16'sd0, 1'b0, "p0000");
        do_issue(-16'sd11520, 1'b1, "p2000");
        send_res(8'sd127, 8'sd0, 8'sd127, 8'sd0,   "p0000_q");
        send_res(8'sd127, 8'sd0, 8'sd0,   8'sd127, "p2000_q");

        load_freq(16'h1FFF);
        enable = 1'b1;
        do_issue(16'sd0, 1'b0, "p0000b");
        check_eq("b2b_valid", 32'(z_valid), 1);
        check_eq("b2b_z", $signed(z_out), 11518);
        enable = 1'b0;
        load_freq(16'h4000);
        tick();
        check_eq("hold_valid", 32'(z_valid), 1);
        check_eq("hold_z", $signed(z_out), 11518);
        do_issue(16'sd11518, 1'b1, "p1fff");
        send_res(-8'sd128, 8'sd5,    -8'sd128, 8'sd5,    "p0000b_q");
        send_res(8'sd127,  -8'sd128, 8'sd127,  -8'sd128, "p1fff_q");

        // Saturating negation in every quadrant.
        load_freq(16'h4000);
        enable = 1'b1;
        do_issue(16'sd0, 1'b0, "sat_i0");
        do_issue(16'sd0, 1'b0, "sat_i1");
        do_issue(16'sd0, 1'b0, "sat_i2");
        do_issue(16'sd0, 1'b1, "sat_i3");
        send_res(-8'sd128, 8'sd100, -8'sd128, 8'sd100,  "sat_q0");
        send_res(-8'sd128, 8'sd100, -8'sd100, -8'sd128, "sat_q1");
        send_res(-8'sd128, 8'sd100, 8'sd127,  -8'sd100, "sat_q2");
        send_res(-8'sd128, 8'sd100, 8'sd100,  8'sd127,  "sat_q3");

        // Two in flight and a third offered (phase 0x3FFE -> -3), then async reset.
        load_freq(16'h1FFF);
        enable = 1'b1;
        do_issue(16'sd0, 1'b0, "rs_i0");
        do_issue(16'sd11518, 1'b0, "rs_i1");
        check_eq("rs_pending_z", $signed(z_out), -3);
        check_eq("rs_busy", 32'(busy), 1);
        enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_z_out",   $signed(z_out), 0);
        check_eq("arst_z_valid", 32'(z_valid), 0);
        check_eq("arst_busy",    32'(busy), 0);
        check_eq("arst_cos",     $signed(cos_out), 0);
        check_eq("arst_sin",     $signed(sin_out), 0);
        tick();
        reset = 1'b0;
        tick();
        res_valid = 1'b1;
        res_cos   = 8'sd127;
        res_sin   = 8'sd0;
        tick();
        res_valid = 1'b0;
        check_eq("orphan_out_valid", 32'(out_valid), 0);
        check_eq("orphan_err", 32'(err_orphan), 1);
        check_eq("orphan_cos", $signed(cos_out), 0);
        tick();
        check_eq("orphan_sticky", 32'(err_orphan), 1);

        // Simultaneous transfer and result at three in flight keeps the count at three.
        load_freq(16'h4000);
        enable = 1'b1;
        do_issue(16'sd0, 1'b0, "sc_i0");
        do_issue(16'sd0, 1'b0, "sc_i1");
        do_issue(16'sd0, 1'b0, "sc_i2");
        check_eq("sc_count_before", 32'(count_dbg), 3);
        check_eq("sc_valid_before", 32'(z_valid), 1);
        z_ready   = 1'b1;
        enable    = 1'b0;
        res_valid = 1'b1;
        res_cos   = 8'sd127;
        res_sin   = 8'sd0;
        tick();
        z_ready   = 1'b0;
        res_valid = 1'b0;
        check_eq("sc_count_after", 32'(count_dbg), 3);
        check_eq("sc_ov",  32'(out_valid), 1);
        check_eq("sc_cos", $signed(cos_out), 127);
        check_eq("sc_sin", $signed(sin_out), 0);
        tick();
        send_res(8'sd127, 8'sd0, 8'sd0,    8'sd127,  "sc_q1");
        send_res(8'sd127, 8'sd0, -8'sd127, 8'sd0,    "sc_q2");
        send_res(8'sd127, 8'sd0, 8'sd0,    -8'sd127, "sc_q3");
        check_eq("sc_busy_end", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
